// File: rtl/div_sequencer.sv
// div_sequencer: radix-2 restoring signed/unsigned divider, quotient -> LO, remainder -> HI.
// Optional DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_req,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             div_busy,
    output logic             div_done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, n_q, n_d, quo_q, quo_d, rem_q, rem_d;
    logic             sg_q, sg_d, qn_q, qn_d, rn_q, rn_d, z_q, z_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] abs_n, abs_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        n_d     = n_q;
        sg_d    = sg_q;
        qn_d    = qn_q;
        rn_d    = rn_q;
        z_d     = z_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        t       = {r_q, a_q[WIDTH-1]} - {1'b0, b_q};
        abs_n   = (sg_q && n_q[WIDTH-1]) ? -n_q : n_q;
        abs_b   = (sg_q && b_q[WIDTH-1]) ? -b_q : b_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = div_req ? PREP : IDLE;
                if (div_req) begin
                    n_d  = dividend;
                    b_d  = divisor;
                    sg_d = div_signed;
                end
            end
            PREP: begin
                a_d     = abs_n;
                b_d     = abs_b;
                r_d     = '0;
                qn_d    = sg_q & (n_q[WIDTH-1] ^ b_q[WIDTH-1]);
                rn_d    = sg_q & n_q[WIDTH-1];
                // zero divisor still iterates so latency stays fixed; FIX overrides the result
                z_d     = (b_q == '0);
                cnt_d   = CW'(WIDTH - 1);
                state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
                if (b_q != '0 && abs_n < abs_b) begin
                    a_d     = '0;
                    r_d     = abs_n;
                    state_d = FIX;
                end
`endif
            end
            CALC: begin
                r_d     = t[WIDTH] ? {r_q[WIDTH-2:0], a_q[WIDTH-1]} : t[WIDTH-1:0];
                a_d     = {a_q[WIDTH-2:0], ~t[WIDTH]};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? FIX : CALC;
            end
            FIX: begin
                quo_d   = z_q ? '1 : (qn_q ? -a_q : a_q);
                rem_d   = z_q ? n_q : (rn_q ? -r_q : r_q);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            quo_d   = quo_q;
            rem_d   = rem_q;
        end
        busy_d = (state_d == PREP) || (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            n_q     <= '0;
            sg_q    <= 1'b0;
            qn_q    <= 1'b0;
            rn_q    <= 1'b0;
            z_q     <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            n_q     <= n_d;
            sg_q    <= sg_d;
            qn_q    <= qn_d;
            rn_q    <= rn_d;
            z_q     <= z_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign div_busy  = busy_q;
    assign div_done  = done_q;
    assign hilo_we   = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed checks of latency, results, flush, back-to-back and reset.
module tb_div_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        div_req = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        flush = 1'b0;
    logic        div_busy, div_done, hilo_we;
    logic [31:0] quotient, remainder;
    int          errors = 0;
    int          checks = 0;

    localparam logic [63:0] BUSY_FULL = 64'h0000_0007_FFFF_FFFE;
    localparam logic [63:0] DONE_FULL = 64'h0000_0008_0000_0000;

    div_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .div_req(div_req), .div_signed(div_signed),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .div_busy(div_busy), .div_done(div_done), .hilo_we(hilo_we),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic run_div(input logic s, input logic [31:0] n, input logic [31:0] d, input int fl,
                           output logic [63:0] bm, output logic [63:0] dm, output logic [63:0] hm,
                           output logic [31:0] q, output logic [31:0] r);
        @(negedge clk);
        div_req = 1'b1; div_signed = s; dividend = n; divisor = d;
        bm = '0; dm = '0; hm = '0; q = '0; r = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1 div_req = 1'b0; flush = 1'b0;
            @(negedge clk);
            bm[c] = div_busy; dm[c] = div_done; hm[c] = hilo_we;
            if (div_done) begin q = quotient; r = remainder; end
            if (c == fl) flush = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({div_busy, div_done, hilo_we, quotient, remainder} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b %b %b %h %h want all zero", div_busy, div_done, hilo_we, quotient, remainder);
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_divu;
        logic [63:0] bm, dm, hm; logic [31:0] q, r;
        run_div(1'b0, 32'd100, 32'd7, -1, bm, dm, hm, q, r);
        chk("divu_busy_mask", bm, BUSY_FULL);
        chk("divu_done_mask", dm, DONE_FULL);
        chk("divu_hilo_mask", hm, DONE_FULL);
        chk("divu_q", {32'd0, q}, 64'd14);
        chk("divu_r", {32'd0, r}, 64'd2);
    endtask

    task automatic test_signed;
        logic [63:0] bm, dm, hm; logic [31:0] q, r;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, bm, dm, hm, q, r);
        chk("div_neg7_2_done", dm, DONE_FULL);
        chk("div_neg7_2_q", {32'd0, q}, 64'hFFFF_FFFD);
        chk("div_neg7_2_r", {32'd0, r}, 64'hFFFF_FFFF);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, -1, bm, dm, hm, q, r);
        chk("div_7_neg2_q", {32'd0, q}, 64'hFFFF_FFFD);
        chk("div_7_neg2_r", {32'd0, r}, 64'd1);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, bm, dm, hm, q, r);
        chk("div_ovf_q", {32'd0, q}, 64'h8000_0000);
        chk("div_ovf_r", {32'd0, r}, 64'd0);
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, -1, bm, dm, hm, q, r);
        chk("divu_big_q", {32'd0, q}, 64'h7FFF_FFFC);
        chk("divu_big_r", {32'd0, r}, 64'd1);
    endtask

    task automatic test_div_zero;
        logic [63:0] bm, dm, hm; logic [31:0] q, r;
        run_div(1'b0, 32'h1234, 32'd0, -1, bm, dm, hm, q, r);
        chk("divz_done_mask", dm, DONE_FULL);
        chk("divz_busy_mask", bm, BUSY_FULL);
        chk("divz_q", {32'd0, q}, 64'hFFFF_FFFF);
        chk("divz_r", {32'd0, r}, 64'h1234);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0, -1, bm, dm, hm, q, r);
        chk("divz_signed_q", {32'd0, q}, 64'hFFFF_FFFF);
        chk("divz_signed_r", {32'd0, r}, 64'hFFFF_FFF9);
    endtask

    task automatic test_flush;
        logic [63:0] bm, dm, hm; logic [31:0] q, r;
        run_div(1'b0, 32'd100, 32'd7, 10, bm, dm, hm, q, r);
        chk("flush_busy_mask", bm, 64'h0000_0000_0000_07FE);
        chk("flush_done_mask", dm, 64'd0);
        chk("flush_hold_q", {32'd0, quotient}, 64'hFFFF_FFFF);
        chk("flush_hold_r", {32'd0, remainder}, 64'hFFFF_FFF9);
    endtask

    task automatic test_back_to_back;
        int n = 0, d1 = 0, d2 = 0;
        logic [31:0] q1 = '0, r1 = '0, q2 = '0, r2 = '0;
        @(negedge clk);
        div_req = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        for (int c = 1; c <= 75; c++) begin
            @(posedge clk);
            #1 if (c == 1 || c == 36) div_req = 1'b0;
            @(negedge clk);
            if (div_done) begin
                n++;
                if (n == 1) begin d1 = c; q1 = quotient; r1 = remainder; end
                else begin d2 = c; q2 = quotient; r2 = remainder; end
            end
            if (c == 34) begin div_req = 1'b1; dividend = 32'd9; divisor = 32'd3; end
        end
        chk("b2b_done_count", 64'(n), 64'd2);
        chk("b2b_first_cycle", 64'(d1), 64'd35);
        chk("b2b_second_cycle", 64'(d2), 64'd70);
        chk("b2b_first_qr", {q1, r1}, {32'd14, 32'd2});
        chk("b2b_second_qr", {q2, r2}, {32'd3, 32'd0});
    endtask

    task automatic test_early_out;
        logic [63:0] bm, dm, hm; logic [31:0] q, r;
        run_div(1'b0, 32'd5, 32'd9, -1, bm, dm, hm, q, r);
`ifdef DIV_EARLY_OUT_EN
        chk("early_done_mask", dm, 64'h8);
        chk("early_busy_mask", bm, 64'h6);
`else
        chk("early_done_mask", dm, DONE_FULL);
        chk("early_busy_mask", bm, BUSY_FULL);
`endif
        chk("early_qr", {q, r}, {32'd0, 32'd5});
        run_div(1'b1, 32'hFFFF_FFFB, 32'd9, -1, bm, dm, hm, q, r);
        chk("early_signed_qr", {q, r}, {32'd0, 32'hFFFF_FFFB});
    endtask

    task automatic test_async_reset;
        logic [63:0] bm, dm, hm; logic [31:0] q, r;
        @(negedge clk);
        div_req = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1 div_req = 1'b0;
        end
        @(negedge clk);
        chk("arst_busy_before", {63'd0, div_busy}, 64'd1);
        rst = 1'b0;
        #1;
        checks++;
        if ({div_busy, div_done, hilo_we, quotient, remainder} !== 67'd0) begin
            errors++;
            $display("FAIL arst_outputs: got %b %b %b %h %h want all zero", div_busy, div_done, hilo_we, quotient, remainder);
        end
        @(negedge clk); rst = 1'b1;
        run_div(1'b0, 32'd100, 32'd7, -1, bm, dm, hm, q, r);
        chk("arst_after_done", dm, DONE_FULL);
        chk("arst_after_qr", {q, r}, {32'd14, 32'd2});
    endtask

    initial begin
        test_reset;
        test_divu;
        test_signed;
        test_div_zero;
        test_flush;
        test_back_to_back;
        test_early_out;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
